// File: rtl/bg_restore_sweeper.sv
// Raster-sweeps a rectangle of screen coordinates out to the background translator/ROM
// and replots the returned colours through a two-stage pipeline to the VGA adapter.
module bg_restore_sweeper #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOR_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  output logic [X_W-1:0]     scan_x,
  output logic [Y_W-1:0]     scan_y,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned XF_W = X_W + 1;
  localparam int unsigned YF_W = Y_W + 1;
  localparam logic [XF_W-1:0] LP_SCR_W = XF_W'(SCREEN_W);
  localparam logic [YF_W-1:0] LP_SCR_H = YF_W'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [X_W-1:0]     r_x0, r_w, r_i;
  logic [Y_W-1:0]     r_y0, r_h, r_j;
  logic [XF_W-1:0]    r_sx;
  logic [YF_W-1:0]    r_sy;
  logic               r_flush_cnt;
  logic               r_s1_valid;
  logic [X_W-1:0]     r_s1_x;
  logic [Y_W-1:0]     r_s1_y;
  logic [X_W-1:0]     r_vga_x;
  logic [Y_W-1:0]     r_vga_y;
  logic [COLOR_W-1:0] r_vga_colour;
  logic               r_vga_plot;
  logic               r_busy;
  logic               r_done;

  logic w_accept;
  logic w_zero;
  logic w_col_last;
  logic w_row_last;
  logic w_visible;
  logic w_advance;
  logic w_s1_valid_d;
  logic w_busy_d;
  logic w_done_d;

  assign w_zero     = (w == '0) || (h == '0);
  assign w_col_last = (r_i == r_w - X_W'(1));
  assign w_row_last = (r_j == r_h - Y_W'(1));
  // Full-width sums so coordinates past the counter width still clip
  assign w_visible  = (r_sx < LP_SCR_W) && (r_sy < LP_SCR_H);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_SWEEP;
      S_SWEEP: if (w_col_last && w_row_last) w_next = S_FLUSH;
      S_FLUSH: if (r_flush_cnt) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_s1_valid_d = 1'b0;
    w_busy_d     = (w_next != S_IDLE);
    w_done_d     = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_SWEEP: begin
        w_advance    = !(w_col_last && w_row_last);
        w_s1_valid_d = w_visible;
      end
      S_DONE:  w_done_d = 1'b1;
      default: ;
    endcase
  end

  // Rectangle latch and raster counters; scan coordinates hold once the sweep ends
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_flush_cnt <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x0 <= x0;
        r_y0 <= y0;
        r_w  <= w;
        r_h  <= h;
        r_i  <= '0;
        r_j  <= '0;
        r_sx <= {1'b0, x0};
        r_sy <= {1'b0, y0};
      end else if (w_advance) begin
        if (w_col_last) begin
          r_i  <= '0;
          r_sx <= {1'b0, r_x0};
          r_j  <= r_j + Y_W'(1);
          r_sy <= r_sy + YF_W'(1);
        end else begin
          r_i  <= r_i + X_W'(1);
          r_sx <= r_sx + XF_W'(1);
        end
      end
      r_flush_cnt <= (r_state == S_FLUSH) ? ~r_flush_cnt : 1'b0;
    end
  end

  // Stage 1 aligns the coordinate with the ROM read; stage 2 drives the plot port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_s1_valid <= w_s1_valid_d;
      r_s1_x     <= r_sx[X_W-1:0];
      r_s1_y     <= r_sy[Y_W-1:0];
      r_vga_plot <= r_s1_valid;
      if (r_s1_valid) begin
        r_vga_x      <= r_s1_x;
        r_vga_y      <= r_s1_y;
        r_vga_colour <= rom_q;
      end
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  assign scan_x     = r_sx[X_W-1:0];
  assign scan_y     = r_sy[Y_W-1:0];
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
